mult32x32_arbiter: RTL and testbench
====================================

Name: mult32x32_arbiter

Overview:
- Shares one mult32x32 multiplier (ports: start, a, b, busy, product) between two independent requesters.
- Grants requests round-robin, latches the winner's operands, and drives the multiplier's start.
- Tracks the multiplier's busy to completion, then returns the 64-bit product with a per-requester done pulse.
- Sits between client blocks and the multiplier. It includes a watchdog against a multiplier that never completes.

Parameters:
- TIMEOUT, 64, maximum cycles spent in WAIT_BUSY plus WAIT_DONE before the operation is aborted with an error (legal range 4..1023).

Ports:
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high reset
- req0  in  1  requester 0 request; held high until ack0
- a0  in  32  requester 0 operand A; held stable while req0=1
- b0  in  32  requester 0 operand B; held stable while req0=1
- req1  in  1  requester 1 request
- a1  in  32  requester 1 operand A
- b1  in  32  requester 1 operand B
- ack0  out  1  one-cycle pulse: requester 0 operands accepted
- ack1  out  1  one-cycle pulse: requester 1 operands accepted
- done0  out  1  one-cycle pulse: result valid for requester 0
- done1  out  1  one-cycle pulse: result valid for requester 1
- err  out  1  qualifies done0/done1: operation timed out
- result  out  64  product; valid only while done0 or done1 is high
- arb_busy  out  1  high in every state except IDLE
- mult_start  out  1  start pulse to the multiplier
- mult_a  out  32  registered operand A to the multiplier
- mult_b  out  32  registered operand B to the multiplier
- mult_busy  in  1  multiplier busy
- mult_product  in  64  multiplier product; valid when busy falls

Behaviour:
- Reset (asynchronous, active-high):
  - state goes to IDLE.
  - Every output goes to 0, including mult_a, mult_b and result.
  - last_grant goes to 1, so requester 0 wins the first tie.
  - The watchdog counter goes to 0.
  - Reset mid-operation discards the in-flight result; no done pulse is issued.
- All outputs are registered (Moore).
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, DELIVER.
- IDLE:
  - If no req, stay.
  - If exactly one req is high, select it.
  - If both are high, select the requester other than last_grant.
  - Latch the selected a/b into mult_a/mult_b, record the selection as owner, and go to ISSUE.
- ISSUE (exactly one cycle):
  - mult_start=1 and ack_owner=1.
  - Clear the watchdog counter; go to WAIT_BUSY.
- WAIT_BUSY:
  - If mult_busy=1, go to WAIT_DONE.
  - Otherwise increment the counter.
- WAIT_DONE:
  - If mult_busy=0, capture mult_product into result and go to DELIVER.
  - Otherwise increment the counter.
- Timeout: in WAIT_BUSY or WAIT_DONE, if the counter reaches TIMEOUT-1 and the normal exit condition is false, go to DELIVER with err set and result forced to 0.
- DELIVER (exactly one cycle):
  - done_owner=1; err is high only on timeout.
  - Set last_grant=owner and go to IDLE.
  - Clear err and result on exit.
- mult_a and mult_b hold their values from ISSUE through DELIVER and must not change while the multiplier is busy.
- A requester that keeps req high after its ack makes a new request, arbitrated in the next IDLE cycle.
- A req arriving during a non-IDLE state waits; it is not lost and causes no glitch on ack.
- Minimum turnaround is 2 cycles in IDLE/DELIVER. Back-to-back requests from both requesters alternate strictly.
- Latency with a multiplier whose busy is high for K cycles starting the cycle after start:
  - req sampled in IDLE at cycle N.
  - ack and start at N+1.
  - done at N+K+3.
- ack0/ack1 are never high together, and neither are done0/done1.

Test Plan:
- Single request: reset, then req0=1, a0=32'h0001_0002, b0=32'h0003_0004, behavioural multiplier with K=8 → ack0 and mult_start high at N+1 only; done0 at N+11; result=64'h0000_0003_000A_0008; err=0; done1 never asserts.
- Simultaneous requests: req0 and req1 high at the same cycle after reset, a0=5, b0=7, a1=32'hFFFF_FFFF, b1=32'hFFFF_FFFF → requester 0 is served first (result 35); requester 1 follows (result 64'hFFFF_FFFE_0000_0001); mult_a/mult_b stay stable while mult_busy is high.
- Round-robin fairness: hold req0 and req1 high for 6 operations → grant order 0,1,0,1,0,1; each done is followed by IDLE for 1 cycle.
- Watchdog: multiplier model ignores start (busy stays 0), TIMEOUT=64 → done0 with err=1 and result=0, 64 cycles after ISSUE; the arbiter is back in IDLE the next cycle and serves a new req normally.
- Stuck busy: busy rises but never falls → the same timeout response, counted from ISSUE.
- Reset mid-operation: assert reset during WAIT_DONE → all outputs are 0 immediately (asynchronous, before the next clock edge); no done is issued after release; the next tie grants requester 0.

Source files
------------

// File: rtl/mult32x32_arbiter.sv
`default_nettype none
//==============================================================================
// mult32x32_arbiter: round-robin sharing of one 32x32 multiplier by two
// requesters, with a watchdog that aborts a multiplier that never completes.
// Rev 1.0
//==============================================================================
module mult32x32_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic        req1,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  output logic        ack0,
  output logic        ack1,
  output logic        done0,
  output logic        done1,
  output logic        err,
  output logic [63:0] result,
  output logic        arb_busy,
  output logic        mult_start,
  output logic [31:0] mult_a,
  output logic [31:0] mult_b,
  input  logic        mult_busy,
  input  logic [63:0] mult_product
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    DELIVER   = 3'd4
  } state_t;

  localparam logic [9:0] C_WDOG_LAST = 10'(TIMEOUT - 1);

  state_t      r_state;
  logic        r_last_grant;
  logic        r_owner;
  logic [9:0]  r_wdog;
  logic        r_ack0;
  logic        r_ack1;
  logic        r_done0;
  logic        r_done1;
  logic        r_err;
  logic [63:0] r_result;
  logic        r_arb_busy;
  logic        r_start;
  logic [31:0] r_mult_a;
  logic [31:0] r_mult_b;

  logic        w_any_req;
  logic        w_pick1;
  logic        w_wdog_expired;

  // On a tie the requester that did not win last time is served.
  assign w_any_req      = req0 | req1;
  assign w_pick1        = req1 & (~req0 | ~r_last_grant);
  assign w_wdog_expired = (r_wdog >= C_WDOG_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_wdog       <= '0;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_done0      <= 1'b0;
      r_done1      <= 1'b0;
      r_err        <= 1'b0;
      r_result     <= '0;
      r_arb_busy   <= 1'b0;
      r_start      <= 1'b0;
      r_mult_a     <= '0;
      r_mult_b     <= '0;
    end else begin
      // Pulse outputs are single-cycle; each transition below re-asserts as needed.
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
      r_err    <= 1'b0;
      r_result <= '0;
      r_start  <= 1'b0;

      case (r_state)
        IDLE: begin
          r_arb_busy <= w_any_req;
          if (w_any_req) begin
            r_owner  <= w_pick1;
            r_mult_a <= w_pick1 ? a1 : a0;
            r_mult_b <= w_pick1 ? b1 : b0;
            r_start  <= 1'b1;
            r_ack0   <= ~w_pick1;
            r_ack1   <= w_pick1;
            r_state  <= ISSUE;
          end
        end

        ISSUE: begin
          r_wdog  <= '0;
          r_state <= WAIT_BUSY;
        end

        // The watchdog counts every cycle spent in either wait state.
        WAIT_BUSY: begin
          if (mult_busy) begin
            r_wdog  <= r_wdog + 10'd1;
            r_state <= WAIT_DONE;
          end else if (w_wdog_expired) begin
            r_done0 <= ~r_owner;
            r_done1 <= r_owner;
            r_err   <= 1'b1;
            r_state <= DELIVER;
          end else begin
            r_wdog <= r_wdog + 10'd1;
          end
        end

        WAIT_DONE: begin
          if (!mult_busy) begin
            r_done0  <= ~r_owner;
            r_done1  <= r_owner;
            r_result <= mult_product;
            r_state  <= DELIVER;
          end else if (w_wdog_expired) begin
            r_done0 <= ~r_owner;
            r_done1 <= r_owner;
            r_err   <= 1'b1;
            r_state <= DELIVER;
          end else begin
            r_wdog <= r_wdog + 10'd1;
          end
        end

        DELIVER: begin
          r_last_grant <= r_owner;
          r_arb_busy   <= 1'b0;
          r_state      <= IDLE;
        end

        default: begin
          r_arb_busy <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  assign ack0       = r_ack0;
  assign ack1       = r_ack1;
  assign done0      = r_done0;
  assign done1      = r_done1;
  assign err        = r_err;
  assign result     = r_result;
  assign arb_busy   = r_arb_busy;
  assign mult_start = r_start;
  assign mult_a     = r_mult_a;
  assign mult_b     = r_mult_b;

endmodule
`default_nettype wire

// File: tb/tb_mult32x32_arbiter.sv
`default_nettype none
//==============================================================================
// tb_mult32x32_arbiter: directed vector table plus corner-case sequences.
// Rev 1.0
//==============================================================================
module tb_mult32x32_arbiter;

  localparam int TIMEOUT = 64;
  localparam int LIMIT   = 300;
  localparam int K       = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic        ack0, ack1, done0, done1, err, arb_busy, mult_start;
  logic [63:0] result;
  logic [31:0] mult_a, mult_b;

  // multiplier model: 0 = normal, 1 = ignores start, 2 = busy never falls
  logic [1:0]  mmode = 2'd0;
  logic        m_busy;
  int          m_cnt;
  logic [63:0] m_prod, m_res;

  int n_pass = 0;
  int n_total = 0;
  int overlap = 0;

  mult32x32_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
    .err(err), .result(result), .arb_busy(arb_busy),
    .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
    .mult_busy(m_busy), .mult_product(m_prod)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0; m_cnt <= 0; m_prod <= '0; m_res <= '0;
    end else if (mult_start && mmode != 2'd1) begin
      m_busy <= 1'b1;
      m_cnt  <= K;
      m_res  <= {32'b0, mult_a} * {32'b0, mult_b};
      m_prod <= 64'hDEAD_BEEF_DEAD_BEEF;
    end else if (m_busy && mmode == 2'd0) begin
      if (m_cnt == 1) begin
        m_busy <= 1'b0;
        m_prod <= m_res;
      end
      m_cnt <= m_cnt - 1;
    end
  end

  always @(negedge clk)
    if ((ack0 && ack1) || (done0 && done1)) overlap++;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [159:0] all_outs();
    return {ack0, ack1, done0, done1, err, arb_busy, mult_start, mult_a, mult_b, result};
  endfunction

  task automatic do_reset();
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Waits for the owner's ack and done; latencies are counted in clock edges.
  task automatic do_op(input string tag, input logic who, input logic [31:0] ea, input logic [31:0] eb,
                       input logic [63:0] eres, input logic eerr, input int ack_lat, input int done_lat);
    int n;
    int bad;
    n = 0;
    do begin @(negedge clk); n++; end while (!(ack0 || ack1) && n < LIMIT);
    check({tag, " ack latency"}, n, ack_lat);
    check({tag, " ack owner"}, {ack1, ack0}, who ? 2'b10 : 2'b01);
    check({tag, " start"}, mult_start, 1'b1);
    check({tag, " operands"}, {mult_a, mult_b}, {ea, eb});
    if (who) req1 = 1'b0; else req0 = 1'b0;
    n = 0; bad = 0;
    do begin
      @(negedge clk); n++;
      if (m_busy && (mult_a !== ea || mult_b !== eb)) bad++;
    end while (!(done0 || done1) && n < LIMIT);
    check({tag, " done latency"}, n, done_lat);
    check({tag, " done owner"}, {done1, done0}, who ? 2'b10 : 2'b01);
    check({tag, " result"}, result, eres);
    check({tag, " err"}, err, eerr);
    check({tag, " operand hold"}, bad, 0);
  endtask

  typedef struct {
    logic        r0;
    logic        r1;
    logic [31:0] a0, b0, a1, b1;
    logic        first;
    logic [63:0] res0, res1;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #1_000_000;
    $display("FAIL global timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    logic [5:0] order;
    logic [5:0] idle_ok;
    int         bad_res;
    int         n;
    int         dones;

    vecs[0] = '{1'b1, 1'b0, 32'h0001_0002, 32'h0003_0004, 32'h0, 32'h0, 1'b0,
                64'h0000_0003_000A_0008, 64'h0};
    vecs[1] = '{1'b1, 1'b1, 32'd5, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0,
                64'd35, 64'hFFFF_FFFE_0000_0001};
    vecs[2] = '{1'b0, 1'b1, 32'h0, 32'h0, 32'h1234_5678, 32'h10, 1'b1,
                64'h0, 64'h0000_0001_2345_6780};
    vecs[3] = '{1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0,
                64'h0, 64'h0};
    vecs[4] = '{1'b0, 1'b1, 32'h0, 32'h0, 32'h8000_0000, 32'd2, 1'b1,
                64'h0, 64'h0000_0001_0000_0000};

    @(negedge clk);
    do_reset();
    check("reset outputs", all_outs(), '0);

    for (int i = 0; i < 5; i++) begin
      do_reset();
      mmode = 2'd0;
      a0 = vecs[i].a0; b0 = vecs[i].b0; a1 = vecs[i].a1; b1 = vecs[i].b1;
      req0 = vecs[i].r0; req1 = vecs[i].r1;
      if (vecs[i].first)
        do_op($sformatf("vec%0d first", i), 1'b1, vecs[i].a1, vecs[i].b1, vecs[i].res1, 1'b0, 1, K + 2);
      else
        do_op($sformatf("vec%0d first", i), 1'b0, vecs[i].a0, vecs[i].b0, vecs[i].res0, 1'b0, 1, K + 2);
      if (vecs[i].r0 && vecs[i].r1)
        do_op($sformatf("vec%0d second", i), 1'b1, vecs[i].a1, vecs[i].b1, vecs[i].res1, 1'b0, 2, K + 2);
    end

    // Round-robin with both requests held throughout.
    do_reset();
    a0 = 32'd3; b0 = 32'd4; a1 = 32'd6; b1 = 32'd7;
    req0 = 1'b1; req1 = 1'b1;
    order = '0; idle_ok = '0; bad_res = 0;
    for (int i = 0; i < 6; i++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!(done0 || done1) && n < LIMIT);
      order[i] = done1;
      if (result !== (done1 ? 64'd42 : 64'd12)) bad_res++;
      if (i == 5) begin req0 = 1'b0; req1 = 1'b0; end
      @(negedge clk);
      idle_ok[i] = !arb_busy;
    end
    check("rr grant order", order, 6'b101010);
    check("rr idle after done", idle_ok, 6'b111111);
    check("rr results", bad_res, 0);

    // Watchdog: the multiplier never raises busy.
    do_reset();
    mmode = 2'd1;
    a0 = 32'd9; b0 = 32'd9; req0 = 1'b1;
    do_op("wdog", 1'b0, 32'd9, 32'd9, 64'h0, 1'b1, 1, TIMEOUT + 1);
    @(negedge clk);
    check("wdog idle after", arb_busy, 1'b0);
    check("wdog err cleared", err, 1'b0);
    mmode = 2'd0;
    a0 = 32'd2; b0 = 32'd3; req0 = 1'b1;
    do_op("wdog recover", 1'b0, 32'd2, 32'd3, 64'd6, 1'b0, 1, K + 2);

    // Stuck busy: busy rises but never falls.
    do_reset();
    mmode = 2'd2;
    a1 = 32'd4; b1 = 32'd4; req1 = 1'b1;
    do_op("stuck", 1'b1, 32'd4, 32'd4, 64'h0, 1'b1, 1, TIMEOUT + 1);
    @(negedge clk);
    check("stuck idle after", arb_busy, 1'b0);

    // Reset during WAIT_DONE.
    do_reset();
    mmode = 2'd0;
    a0 = 32'd7; b0 = 32'd7; a1 = 32'd10; b1 = 32'd10; req0 = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!ack0 && n < LIMIT);
    req0 = 1'b0;
    repeat (3) @(negedge clk);
    check("midop busy before reset", {arb_busy, mult_a}, {1'b1, 32'd7});
    #2 reset = 1'b1;
    #1 check("midop async clear", all_outs(), '0);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    repeat (20) begin @(negedge clk); if (done0 || done1) dones++; end
    check("midop no done", dones, 0);
    req0 = 1'b1; req1 = 1'b1;
    do_op("post-reset tie first", 1'b0, 32'd7, 32'd7, 64'd49, 1'b0, 1, K + 2);
    do_op("post-reset tie second", 1'b1, 32'd10, 32'd10, 64'd100, 1'b0, 2, K + 2);

    check("ack/done exclusivity", overlap, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
